// File: rtl/pipo_pkg.sv
// Shared width, reset value and word type for the 16-bit PIPO holding register.
package pipo_pkg;
  localparam int PIPO_WIDTH = 16;
  localparam logic [PIPO_WIDTH-1:0] PIPO_RESET_VALUE = '0;
  typedef logic [PIPO_WIDTH-1:0] pipo_word_t;
endpackage

// File: rtl/pipo_dff_bit.sv
// Single D flip-flop with synchronous active-high reset to a per-bit reset value.
module pipo_dff_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= RESET_VALUE;
    else       r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/parallel_in_parallel_out_pipo_16_bit.sv
// Parallel-in/parallel-out register: loads the whole input word on every rising edge.
module parallel_in_parallel_out_pipo_16_bit
  import pipo_pkg::*;
#(
  parameter int               WIDTH       = PIPO_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = PIPO_RESET_VALUE
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  output logic [WIDTH-1:0] Parallel_Data_Out
);
  // Bits are independent flops, so the output is flop-driven with no cross-bit path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pipo_dff_bit #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .i_clk (Clk_In),
      .i_rst (Reset_In),
      .i_d   (Parallel_Data_In[i]),
      .o_q   (Parallel_Data_Out[i])
    );
  end
endmodule

// File: tb/tb_parallel_in_parallel_out_pipo_16_bit.sv
// Directed bench for the 16-bit PIPO: drive on falling edge, check 1 ns after rising edge.
`timescale 1ns/1ps
module tb_parallel_in_parallel_out_pipo_16_bit;
  import pipo_pkg::*;

  logic       clk;
  logic       rst;
  pipo_word_t din;
  pipo_word_t dout;
  int         n_tests;
  int         n_fail;

  parallel_in_parallel_out_pipo_16_bit dut (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Parallel_Data_In  (din),
    .Parallel_Data_Out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input pipo_word_t obs, input pipo_word_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input pipo_word_t d);
    @(negedge clk);
    rst = r;
    din = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pipo_word_t prev;
    pipo_word_t w;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    din = 'x;

    // 1: reset with unknown input
    after_edge();
    chk("reset_clear", dout, 16'h0000);

    // 2: first load, output held until the edge
    drive(1'b0, 16'hA5A5);
    #1;
    chk("a5a5_before_edge", dout, 16'h0000);
    after_edge();
    chk("a5a5_after_edge", dout, 16'hA5A5);

    // 3: back-to-back words
    drive(1'b0, 16'h1234);
    after_edge();
    chk("b2b_1234", dout, 16'h1234);
    drive(1'b0, 16'hFFFF);
    #1;
    chk("b2b_hold_1234", dout, 16'h1234);
    after_edge();
    chk("b2b_ffff", dout, 16'hFFFF);
    drive(1'b0, 16'h0000);
    after_edge();
    chk("b2b_0000", dout, 16'h0000);

    // 4: reset has priority over data on the same edge
    drive(1'b0, 16'h7777);
    after_edge();
    chk("pre_reset_load", dout, 16'h7777);
    drive(1'b1, 16'hBEEF);
    after_edge();
    chk("beef_under_reset", dout, 16'h0000);
    drive(1'b0, 16'hBEEF);
    #1;
    chk("beef_hold_after_rst_fall", dout, 16'h0000);
    after_edge();
    chk("beef_after_reset", dout, 16'hBEEF);

    // 5: glitches between edges are not captured
    drive(1'b0, 16'h5555);
    #1 din = 16'hAAAA;
    #1;
    chk("toggle_no_effect", dout, 16'hBEEF);
    din = 16'h5555;
    after_edge();
    chk("toggle_sampled", dout, 16'h5555);
    drive(1'b0, 16'h5555);
    #1 din = 16'hAAAA;
    after_edge();
    chk("toggle_last_value", dout, 16'hAAAA);

    // 6: random words against a one-deep scoreboard
    prev = 16'hAAAA;
    for (int i = 0; i < 10; i++) begin
      w = pipo_word_t'($urandom_range(0, 16'hFFFF));
      drive(1'b0, w);
      #1;
      chk($sformatf("rand_hold_%0d", i), dout, prev);
      after_edge();
      chk($sformatf("rand_load_%0d", i), dout, w);
      prev = w;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
